// File: rtl/input_debouncer.sv
// input_debouncer: synchronizes a raw 1-bit input and qualifies
// level changes over a run of stable samples before updating dout.
module input_debouncer #(
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_W         = 3
) (
  input  logic clk,
  input  logic async_reset_n,
  input  logic din,
  input  logic enable,
  output logic dout,
  output logic rise_pulse,
  output logic fall_pulse,
  output logic busy
);

  typedef enum logic [1:0] {
    IDLE_LOW,
    CHECK_HIGH,
    IDLE_HIGH,
    CHECK_LOW
  } state_t;

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             sync1, sync2;
  logic             dout_n, rise_n, fall_n;

  // two-flop synchronizer, runs regardless of enable
  always_ff @(posedge clk or negedge async_reset_n) begin
    if (!async_reset_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= din;
      sync2 <= sync1;
    end
  end

  // state, counter and registered outputs
  always_ff @(posedge clk or negedge async_reset_n) begin
    if (!async_reset_n) begin
      state      <= IDLE_LOW;
      cnt        <= '0;
      dout       <= 1'b0;
      rise_pulse <= 1'b0;
      fall_pulse <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      dout       <= dout_n;
      rise_pulse <= rise_n;
      fall_pulse <= fall_n;
    end
  end

  // next-state: qualify a change over STABLE_CYCLES+1 samples
  always_comb begin
    state_n = state;
    cnt_n   = '0;
    dout_n  = dout;
    rise_n  = 1'b0;
    fall_n  = 1'b0;
    unique case (state)
      IDLE_LOW: begin
        if (enable && sync2) begin
          state_n = CHECK_HIGH;
          cnt_n   = ONE;
        end
      end
      CHECK_HIGH: begin
        if (!enable || !sync2) begin
          state_n = IDLE_LOW;
        end else if (cnt == LIMIT) begin
          state_n = IDLE_HIGH;
          dout_n  = 1'b1;
          rise_n  = 1'b1;
        end else begin
          cnt_n = cnt + ONE;
        end
      end
      IDLE_HIGH: begin
        if (enable && !sync2) begin
          state_n = CHECK_LOW;
          cnt_n   = ONE;
        end
      end
      CHECK_LOW: begin
        if (!enable || sync2) begin
          state_n = IDLE_HIGH;
        end else if (cnt == LIMIT) begin
          state_n = IDLE_LOW;
          dout_n  = 1'b0;
          fall_n  = 1'b1;
        end else begin
          cnt_n = cnt + ONE;
        end
      end
      default: begin
        state_n = IDLE_LOW;
        dout_n  = 1'b0;
      end
    endcase
  end

  assign busy = (state == CHECK_HIGH) || (state == CHECK_LOW);

endmodule

// File: tb/tb_input_debouncer.sv
// tb_input_debouncer: directed and random stimulus checked against
// a run-length model of the debouncer.
module tb_input_debouncer;

  localparam int N = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic din = 1'b0;
  logic enable = 1'b1;
  logic dout, rise_pulse, fall_pulse, busy;

  int total = 0;
  int bad = 0;

  // model: two-sample delay line plus count of qualifying samples
  logic m_p1 = 1'b0;
  logic m_p2 = 1'b0;
  logic m_dout = 1'b0;
  logic m_rise = 1'b0;
  logic m_fall = 1'b0;
  int   m_run = 0;

  int rises;
  int falls;

  input_debouncer #(.STABLE_CYCLES(N), .CNT_W(3)) dut (
    .clk          (clk),
    .async_reset_n(rst_n),
    .din          (din),
    .enable       (enable),
    .dout         (dout),
    .rise_pulse   (rise_pulse),
    .fall_pulse   (fall_pulse),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic obs,
                       input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic check_int(input string tag, input int obs,
                           input int exp);
    total++;
    assert (obs == exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    m_p1 = 1'b0;
    m_p2 = 1'b0;
    m_dout = 1'b0;
    m_rise = 1'b0;
    m_fall = 1'b0;
    m_run = 0;
  endtask

  task automatic step(input logic d, input logic e);
    logic s;
    din = d;
    enable = e;
    @(posedge clk);
    s = m_p2;
    m_rise = 1'b0;
    m_fall = 1'b0;
    if (!e || s == m_dout) begin
      m_run = 0;
    end else begin
      m_run++;
      if (m_run == N + 1) begin
        m_dout = s;
        m_rise = s;
        m_fall = !s;
        m_run = 0;
      end
    end
    m_p2 = m_p1;
    m_p1 = d;
    #1;
    check("dout", dout, m_dout);
    check("rise", rise_pulse, m_rise);
    check("fall", fall_pulse, m_fall);
    check("busy", busy, m_run > 0);
    if (rise_pulse === 1'b1) rises++;
    if (fall_pulse === 1'b1) falls++;
  endtask

  // assert reset mid-cycle, verify async clear, hold, release mid-cycle
  task automatic pulse_reset(input int edges);
    #3;
    rst_n = 1'b0;
    #1;
    check("rst_dout", dout, 1'b0);
    check("rst_rise", rise_pulse, 1'b0);
    check("rst_fall", fall_pulse, 1'b0);
    check("rst_busy", busy, 1'b0);
    for (int i = 0; i < edges; i++) @(posedge clk);
    #3;
    rst_n = 1'b1;
    model_clear();
  endtask

  initial begin
    #1;
    rst_n = 1'b0;
    #1;
    check("init_dout", dout, 1'b0);
    check("init_busy", busy, 1'b0);
    check("init_rise", rise_pulse, 1'b0);
    #5;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1);

    // clean rise: busy after steps 3..6, dout after step 7
    rises = 0;
    for (int i = 1; i <= 9; i++) begin
      step(1'b1, 1'b1);
      if (i == 2) check("rise_busy_lo", busy, 1'b0);
      if (i == 3) check("rise_busy_hi", busy, 1'b1);
      if (i == 6) check("rise_pre", dout, 1'b0);
      if (i == 7) check("rise_pulse", rise_pulse, 1'b1);
      if (i == 7) check("rise_dout", dout, 1'b1);
    end
    check_int("rise_count", rises, 1);

    // async reset from IDLE_HIGH
    pulse_reset(2);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1);

    // bounce: 1,1,1,0 then 1 held; rise after step 11
    rises = 0;
    step(1'b1, 1'b1);
    step(1'b1, 1'b1);
    step(1'b1, 1'b1);
    step(1'b0, 1'b1);
    for (int i = 5; i <= 14; i++) begin
      step(1'b1, 1'b1);
      if (i == 6) check("bnc_busy_drop", busy, 1'b0);
      if (i == 10) check("bnc_pre", dout, 1'b0);
      if (i == 11) check("bnc_dout", dout, 1'b1);
    end
    check_int("bnc_count", rises, 1);

    // clean fall
    rises = 0;
    falls = 0;
    for (int i = 1; i <= 9; i++) begin
      step(1'b0, 1'b1);
      if (i == 6) check("fall_pre", dout, 1'b1);
      if (i == 7) check("fall_dout", dout, 1'b0);
      if (i == 7) check("fall_pulse", fall_pulse, 1'b1);
    end
    check_int("fall_count", falls, 1);
    check_int("fall_norise", rises, 0);

    // enable abort at the 4th edge of a rise
    for (int i = 1; i <= 12; i++) begin
      step(1'b1, i != 4);
      if (i == 4) check("abort_busy", busy, 1'b0);
      if (i == 5) check("abort_reenter", busy, 1'b1);
      if (i == 8) check("abort_pre", dout, 1'b0);
      if (i == 9) check("abort_dout", dout, 1'b1);
    end
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1);

    // reset mid-CHECK then full latency after release
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1);
    check("mid_busy", busy, 1'b1);
    pulse_reset(5);
    for (int i = 1; i <= 8; i++) begin
      step(1'b1, 1'b1);
      if (i == 6) check("mid_pre", dout, 1'b0);
      if (i == 7) check("mid_dout", dout, 1'b1);
    end

    // random runs with occasional enable drops and resets
    for (int k = 0; k < 300; k++) begin
      logic v;
      int len;
      v = 1'($urandom_range(0, 1));
      len = $urandom_range(1, 9);
      for (int j = 0; j < len; j++)
        step(v, $urandom_range(0, 15) != 0);
      if ($urandom_range(0, 60) == 0) pulse_reset(1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/input_debouncer.md
Name: input_debouncer

Overview:
- Conditions a raw, asynchronous 1-bit input (push-button or switch) into a clean, synchronous level for the D input of the team's rising-edge flip-flop stage.
- Provides one-cycle rise/fall strobes for downstream sequential logic.
- Built from a 2-flop synchronizer, a stability counter and a 4-state FSM.

Parameters:
- STABLE_CYCLES, 4, consecutive synchronized samples (after the first) needed before dout changes; legal range >=1
- CNT_W, 3, stability counter width; must satisfy 2^CNT_W > STABLE_CYCLES

Ports:
- clk  input  1  single clock; all state updates on the rising edge
- async_reset_n  input  1  asynchronous, active-low reset; clears all state immediately
- din  input  1  raw, unsynchronized input
- enable  input  1  1 = debounce active; 0 = abort any pending change and hold dout
- dout  output  1  debounced level, registered
- rise_pulse  output  1  high for exactly one cycle when dout goes 0->1
- fall_pulse  output  1  high for exactly one cycle when dout goes 1->0
- busy  output  1  high while a candidate change is being qualified (state CHECK_*)

Behaviour:
- Reset: async_reset_n=0 forces, without waiting for clk, sync1=sync2=0, state=IDLE_LOW, cnt=0, dout=0, rise_pulse=0, fall_pulse=0, busy=0. Release is synchronous to the next clk edge.
- Synchronizer: sync1<=din; sync2<=sync1. Runs every edge regardless of enable. The FSM only ever reads sync2.
- States: IDLE_LOW (dout=0), CHECK_HIGH, IDLE_HIGH (dout=1), CHECK_LOW.
- IDLE_LOW: if enable && sync2=1, go to CHECK_HIGH with cnt<=1. Otherwise stay, cnt<=0.
- CHECK_HIGH:
  - enable=0 or sync2=0: go to IDLE_LOW, cnt<=0 (bounce or abort).
  - else if cnt==STABLE_CYCLES: go to IDLE_HIGH, dout<=1, rise_pulse<=1.
  - else cnt<=cnt+1.
- IDLE_HIGH and CHECK_LOW: mirror of the two states above with polarity inverted; completion sets dout<=0 and fall_pulse<=1.
- Outputs are registered.
  - rise_pulse/fall_pulse default to 0 every cycle; they are high only in the cycle immediately following the transition edge, which is the first cycle of the new dout value.
  - busy = (state==CHECK_HIGH || state==CHECK_LOW).
- Latency: if din is sampled high at N+1 consecutive edges k..k+N (N=STABLE_CYCLES), dout=1 after edge k+N+2. busy is high after edges k+2..k+N+1. Falls are symmetric.
- Any opposite sample during CHECK_* discards progress. Requalification restarts from cnt=1 at the next matching sample.
- cnt never exceeds STABLE_CYCLES; no wrap-around is possible.
- dout changes only on CHECK_*->IDLE_* completion. There is never a glitch, and never both pulses in one cycle.
- enable=0 for one edge during CHECK_* returns the FSM to the matching IDLE state. dout is unchanged and no pulse is generated.
- Reset mid-CHECK: the pending change is lost and the synchronizer is cleared. After release, full N+2 latency applies from the first edge after release.

Test Plan:
- Async reset: assert async_reset_n=0 midway between edges with FSM in IDLE_HIGH -> dout, rise_pulse, fall_pulse, busy all 0 before the next edge.
- Clean rise (N=4, enable=1): din 0->1 before edge 10, held -> busy=1 after edges 12..15; dout=1 after edge 16; rise_pulse=1 only between edges 16 and 17.
- Bounce: din=1 at edges 10-12, 0 at edge 13, 1 from edge 14 -> busy drops after edge 15; dout=1 after edge 20; exactly one rise_pulse over the whole window.
- Clean fall: from dout=1, din 1->0 before edge 30, held -> dout=0 after edge 36; fall_pulse=1 for one cycle; rise_pulse stays 0.
- Enable abort: clean rise at edge 10, enable=0 only at edge 13 -> FSM returns to IDLE_LOW and busy drops after edge 13; CHECK_HIGH re-entered at edge 14; dout=1 after edge 18.
- Reset mid-CHECK: rise at edge 10, reset pulse between edges 13 and 14 released before edge 20, din held 1 -> dout stays 0 through edge 25; dout=1 after edge 26 (20+6).
